arm7tdmi_tap_controller: RTL and testbench

// IEEE 1149.1 JTAG TAP controller for the ARM7TDMI debug path: 16-state TAP FSM, 4-bit instruction register, BYPASS and IDCODE data registers.

---
 rtl/arm7tdmi_tap_controller.sv | 211 +++++++++++++++++++++
 tb/tb_arm7tdmi_tap_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_tap_controller.sv
// -----------------------------------------------------------------------------
// arm7tdmi_tap_controller
//
// IEEE 1149.1 TAP controller for the ARM7TDMI debug path. Holds the 16-state
// TAP FSM, a 4-bit instruction register with its shift stage, and the BYPASS
// and IDCODE data registers. The active instruction is decoded into one-hot
// chain-select strobes, and TDO is muxed from whichever register is active.
//
// Ports
//   tck                 : TAP clock; every state change happens on its rising edge
//   trst                : synchronous active-high reset
//   tms, tdi            : TAP mode select and serial data in
//   tdo                 : serial data out (combinational mux)
//   <state flags>       : one-hot decode of the TAP state (16 outputs)
//   bypass_select, idcode_select, ice_select, scan_n_select
//                       : one-hot decode of current_ir
//   ice_tdo, scan_n_tdo : serial outputs of the external ICE / SCAN_N chains
//   current_ir          : active (updated) instruction
// -----------------------------------------------------------------------------
module arm7tdmi_tap_controller #(
  parameter logic [31:0] IDCODE_VAL = 32'h3F0F0F0F,
  parameter logic [3:0]  IR_RESET   = 4'hE
) (
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       test_logic_reset,
  output logic       run_test_idle,
  output logic       select_dr_scan,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       exit1_dr,
  output logic       pause_dr,
  output logic       exit2_dr,
  output logic       update_dr,
  output logic       select_ir_scan,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       exit1_ir,
  output logic       pause_ir,
  output logic       exit2_ir,
  output logic       update_ir,
  output logic       bypass_select,
  output logic       idcode_select,
  output logic       ice_select,
  output logic       scan_n_select,
  input  logic       ice_tdo,
  input  logic       scan_n_tdo,
  output logic [3:0] current_ir
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI,
    S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
  } tap_state_e;

  tap_state_e  state_q, state_d;
  logic [3:0]  ir_sr_q;
  logic [3:0]  current_ir_q;
  logic        bypass_q;
  logic [31:0] id_sr_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of the order blocks are evaluated.
  always_ff @(posedge tck) begin
    if (trst) state_q <= S_TLR;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic (standard 1149.1 transitions)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TLR:    state_d = tms ? S_TLR    : S_RTI;
      S_RTI:    state_d = tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: state_d = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: state_d = tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  state_d = tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: state_d = tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: state_d = tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: state_d = tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: state_d = tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: state_d = tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: state_d = tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  state_d = tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: state_d = tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: state_d = tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: state_d = tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: state_d = tms ? S_SEL_DR : S_RTI;
      default:  state_d = S_TLR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: one-hot state flags
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    test_logic_reset = 1'b0;
    run_test_idle    = 1'b0;
    select_dr_scan   = 1'b0;
    capture_dr       = 1'b0;
    shift_dr         = 1'b0;
    exit1_dr         = 1'b0;
    pause_dr         = 1'b0;
    exit2_dr         = 1'b0;
    update_dr        = 1'b0;
    select_ir_scan   = 1'b0;
    capture_ir       = 1'b0;
    shift_ir         = 1'b0;
    exit1_ir         = 1'b0;
    pause_ir         = 1'b0;
    exit2_ir         = 1'b0;
    update_ir        = 1'b0;
    unique case (state_q)
      S_TLR:    test_logic_reset = 1'b1;
      S_RTI:    run_test_idle    = 1'b1;
      S_SEL_DR: select_dr_scan   = 1'b1;
      S_CAP_DR: capture_dr       = 1'b1;
      S_SH_DR:  shift_dr         = 1'b1;
      S_EX1_DR: exit1_dr         = 1'b1;
      S_PAU_DR: pause_dr         = 1'b1;
      S_EX2_DR: exit2_dr         = 1'b1;
      S_UPD_DR: update_dr        = 1'b1;
      S_SEL_IR: select_ir_scan   = 1'b1;
      S_CAP_IR: capture_ir       = 1'b1;
      S_SH_IR:  shift_ir         = 1'b1;
      S_EX1_IR: exit1_ir         = 1'b1;
      S_PAU_IR: pause_ir         = 1'b1;
      S_EX2_IR: exit2_ir         = 1'b1;
      S_UPD_IR: update_ir        = 1'b1;
      default:  test_logic_reset = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction and data registers, acting on the state being left
  // ---------------------------------------------------------------------------
  // The Capture->Shift edge only loads; shifting starts on the first edge that
  // leaves a Shift state, including the Shift->Exit1 edge. A reset mid-scan
  // throws away ir_sr_q without ever committing it to current_ir_q.
  always_ff @(posedge tck) begin
    if (trst) begin
      ir_sr_q      <= 4'b0001;
      current_ir_q <= IR_RESET;
      bypass_q     <= 1'b0;
      id_sr_q      <= IDCODE_VAL;
    end else begin
      unique case (state_q)
        S_TLR:    current_ir_q <= IR_RESET;
        S_CAP_IR: ir_sr_q      <= 4'b0001;
        S_SH_IR:  ir_sr_q      <= {tdi, ir_sr_q[3:1]};
        S_UPD_IR: current_ir_q <= ir_sr_q;
        S_CAP_DR: begin
          bypass_q <= 1'b0;
          id_sr_q  <= IDCODE_VAL;
        end
        S_SH_DR: begin
          bypass_q <= tdi;
          id_sr_q  <= {tdi, id_sr_q[31:1]};
        end
        default: ;
      endcase
    end
  end

  assign current_ir = current_ir_q;

  // ---------------------------------------------------------------------------
  // Instruction decode: exactly one chain select; anything not listed is BYPASS
  // ---------------------------------------------------------------------------
  always_comb begin
    bypass_select = 1'b0;
    idcode_select = 1'b0;
    ice_select    = 1'b0;
    scan_n_select = 1'b0;
    unique case (current_ir_q)
      4'hE:             idcode_select = 1'b1;
      4'h2:             scan_n_select = 1'b1;
      4'h0, 4'h3, 4'hC: ice_select    = 1'b1;
      default:          bypass_select = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // TDO mux
  // ---------------------------------------------------------------------------
  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_sr_q[0];
    end else if (shift_dr) begin
      unique case (1'b1)
        idcode_select: tdo = id_sr_q[0];
        ice_select:    tdo = ice_tdo;
        scan_n_select: tdo = scan_n_tdo;
        default:       tdo = bypass_q;
      endcase
    end
  end

endmodule

// File: tb/tb_arm7tdmi_tap_controller.sv
// -----------------------------------------------------------------------------
// tb_arm7tdmi_tap_controller
//
// Drives directed TAP sequences and then random tms/tdi/trst traffic, comparing
// the DUT against a behavioural reference: the TAP graph is expressed as one
// rule table shared by the DR and IR columns, and each scan register is held
// as a bit queue (capture loads it, shift pops the front and appends tdi).
// -----------------------------------------------------------------------------
module tb_arm7tdmi_tap_controller;

  localparam logic [31:0] IDCODE = 32'h3F0F0F0F;

  // Reference state numbering: also the bit order of the packed flag vector.
  localparam int TLR = 0, RTI = 1, SDR = 2, SIR = 9;
  localparam int SH_DR = 4, SH_IR = 11;

  // Column rules for Select..Update (offset from the column's Select state).
  localparam int COL0 [7] = '{1, 2, 2, 4, 4, 2, -1};
  localparam int COL1 [7] = '{-1, 3, 3, 6, 5, 6, -1};

  localparam int K_BYPASS = 0, K_IDCODE = 1, K_ICE = 2, K_SCAN = 3;

  logic       tck = 1'b0;
  logic       trst = 1'b1, tms = 1'b1, tdi = 1'b0;
  logic       ice_tdo = 1'b0, scan_n_tdo = 1'b0;
  logic       tdo;
  logic       test_logic_reset, run_test_idle, select_dr_scan, capture_dr, shift_dr;
  logic       exit1_dr, pause_dr, exit2_dr, update_dr;
  logic       select_ir_scan, capture_ir, shift_ir, exit1_ir, pause_ir, exit2_ir, update_ir;
  logic       bypass_select, idcode_select, ice_select, scan_n_select;
  logic [3:0] current_ir;

  arm7tdmi_tap_controller dut (
    .tck              (tck),
    .trst             (trst),
    .tms              (tms),
    .tdi              (tdi),
    .tdo              (tdo),
    .test_logic_reset (test_logic_reset),
    .run_test_idle    (run_test_idle),
    .select_dr_scan   (select_dr_scan),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .exit1_dr         (exit1_dr),
    .pause_dr         (pause_dr),
    .exit2_dr         (exit2_dr),
    .update_dr        (update_dr),
    .select_ir_scan   (select_ir_scan),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .exit1_ir         (exit1_ir),
    .pause_ir         (pause_ir),
    .exit2_ir         (exit2_ir),
    .update_ir        (update_ir),
    .bypass_select    (bypass_select),
    .idcode_select    (idcode_select),
    .ice_select       (ice_select),
    .scan_n_select    (scan_n_select),
    .ice_tdo          (ice_tdo),
    .scan_n_tdo       (scan_n_tdo),
    .current_ir       (current_ir)
  );

  always #5 tck = ~tck;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit model_valid = 1'b0;
  int m_state = TLR;
  int m_ir    = 14;
  bit ir_q[$];
  bit dr_q[$];
  logic last_tdo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_next(int s, bit t);
    int base, c;
    if (s == TLR) return t ? TLR : RTI;
    if (s == RTI) return t ? SDR : RTI;
    base = (s >= SIR) ? SIR : SDR;
    c    = s - base;
    if (c == 0 && t) return (base == SDR) ? SIR : TLR;
    if (c == 6)      return t ? SDR : RTI;
    return base + (t ? COL1[c] : COL0[c]);
  endfunction

  function automatic int kind_of(int ir);
    if (ir == 14) return K_IDCODE;
    if (ir == 2)  return K_SCAN;
    if (ir == 0 || ir == 3 || ir == 12) return K_ICE;
    return K_BYPASS;
  endfunction

  function automatic int ir_q_value();
    int v = 0;
    foreach (ir_q[i]) v |= int'(ir_q[i]) << i;
    return v;
  endfunction

  task automatic model_advance(input bit t_ms, input bit t_di, input bit t_rst);
    if (t_rst) begin
      m_state = TLR;
      m_ir    = 14;
      ir_q    = '{1'b1, 1'b0, 1'b0, 1'b0};
      dr_q    = '{1'b0};
      model_valid = 1'b1;
      return;
    end
    case (m_state)
      TLR:     m_ir = 14;
      SIR + 1: ir_q = '{1'b1, 1'b0, 1'b0, 1'b0};
      SH_IR: begin
        void'(ir_q.pop_front());
        ir_q.push_back(t_di);
      end
      SIR + 6: m_ir = ir_q_value();
      SDR + 1: begin
        dr_q.delete();
        if (kind_of(m_ir) == K_IDCODE) begin
          for (int i = 0; i < 32; i++) dr_q.push_back(IDCODE[i]);
        end else begin
          dr_q.push_back(1'b0);
        end
      end
      SH_DR: begin
        void'(dr_q.pop_front());
        dr_q.push_back(t_di);
      end
      default: ;
    endcase
    m_state = model_next(m_state, t_ms);
  endtask

  task automatic compare_all();
    logic [15:0] flags;
    logic [3:0]  sels;
    logic        exp_tdo;
    int          k;
    flags = {update_ir, exit2_ir, pause_ir, exit1_ir, shift_ir, capture_ir, select_ir_scan,
             update_dr, exit2_dr, pause_dr, exit1_dr, shift_dr, capture_dr, select_dr_scan,
             run_test_idle, test_logic_reset};
    sels  = {scan_n_select, ice_select, idcode_select, bypass_select};
    k     = kind_of(m_ir);
    exp_tdo = 1'b0;
    if (m_state == SH_IR) exp_tdo = ir_q[0];
    else if (m_state == SH_DR) begin
      if (k == K_ICE)       exp_tdo = ice_tdo;
      else if (k == K_SCAN) exp_tdo = scan_n_tdo;
      else                  exp_tdo = dr_q[0];
    end
    check("state_flags", 32'(flags), 32'(1) << m_state);
    check("current_ir", 32'(current_ir), 32'(m_ir));
    check("selects", 32'(sels), 32'(1) << k);
    check("tdo", 32'(tdo), 32'(exp_tdo));
  endtask

  // One TCK cycle: drive after the falling edge, check mid-low-phase, then let
  // the model follow the rising edge.
  task automatic step(input bit t_ms, input bit t_di, input bit t_rst);
    @(negedge tck);
    tms        = t_ms;
    tdi        = t_di;
    trst       = t_rst;
    ice_tdo    = 1'($urandom);
    scan_n_tdo = 1'($urandom);
    #1;
    last_tdo = tdo;
    if (model_valid) compare_all();
    @(posedge tck);
    model_advance(t_ms, t_di, t_rst);
  endtask

  task automatic go_rti();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // From RTI: shift v LSB first into IR, update, return to RTI.
  task automatic load_ir(input logic [3:0] v);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // From RTI to Shift-DR.
  task automatic to_shift_dr();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] word;
    bit          b;

    // Reset held for 5 edges, then released.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    #2;
    check("rst_tlr", 32'(test_logic_reset), 32'd1);
    check("rst_ir", 32'(current_ir), 32'hE);
    check("rst_idcode_sel", 32'(idcode_select), 32'd1);

    // IR load of 0xC via the documented tms/tdi sequence.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2;
    check("intest_ir", 32'(current_ir), 32'hC);
    check("intest_ice_sel", 32'(ice_select), 32'd1);
    check("intest_rti", 32'(run_test_idle), 32'd1);

    // Six tms=1 edges from Shift-DR land in Test-Logic-Reset.
    to_shift_dr();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    #2;
    check("tms_escape_tlr", 32'(test_logic_reset), 32'd1);
    check("tms_escape_ir", 32'(current_ir), 32'hE);

    // IDCODE streams out LSB first.
    step(1'b0, 1'b0, 1'b0);
    to_shift_dr();
    word = '0;
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'($urandom), 1'b0);
      word[i] = last_tdo;
    end
    check("idcode_stream", word, IDCODE);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // BYPASS: one-edge delay, first bit 0.
    load_ir(4'hF);
    to_shift_dr();
    word = '0;
    step(1'b0, 1'b1, 1'b0); word[0] = last_tdo;
    step(1'b0, 1'b0, 1'b0); word[1] = last_tdo;
    step(1'b1, 1'b1, 1'b0); word[2] = last_tdo;
    check("bypass_lag", word, 32'b010);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    load_ir(4'h1);
    #2;
    check("undef_bypass_sel", 32'(bypass_select), 32'd1);

    // SCAN_N passthrough and IR capture pattern.
    load_ir(4'h2);
    #2;
    check("scan_n_sel", 32'(scan_n_select), 32'd1);
    to_shift_dr();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'($urandom), 1'b0);
      check("scan_n_tdo", 32'(last_tdo), 32'(scan_n_tdo));
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    word = '0;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 1'b0, 1'b0);
      word[i] = last_tdo;
    end
    check("ir_capture", word, 32'b0001);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of an IR scan discards it.
    load_ir(4'h3);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    #2;
    check("abort_tlr", 32'(test_logic_reset), 32'd1);
    check("abort_ir", 32'(current_ir), 32'hE);
    go_rti();

    // Random traffic; tms leans low so scans run for a while.
    for (int i = 0; i < 3000; i++) begin
      b = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 9) < 4, 1'($urandom), b);
    end
    step(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
